// File: rtl/chip8_defs_pkg.sv
// -----------------------------------------------------------------------------
// chip8_defs -- definitions shared by the CHIP-8 cpu, gpu and sprite blitter.
//   SCREEN_W / SCREEN_H : display geometry in pixels
//   SPRITE_ROWS         : maximum sprite height (rows carried by sprite_data)
//   gpu_state_e         : blitter FSM state encoding
// -----------------------------------------------------------------------------
package chip8_defs;

  localparam int SCREEN_W    = 64;
  localparam int SCREEN_H    = 32;
  localparam int SPRITE_ROWS = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } gpu_state_e;

endpackage

// File: rtl/sprite_row_xor.sv
// -----------------------------------------------------------------------------
// sprite_row_xor -- combinational merge of one sprite byte into one
// framebuffer row.
//   i_old_row : current framebuffer row, bit c = column c
//   i_byte    : sprite byte, bit 7 is the leftmost pixel
//   i_x0      : sprite X origin (0..63)
//   o_new_row : i_old_row with the byte XORed in at columns x0..x0+7
//   o_collide : 1 when a lit pixel of i_old_row is turned off
// Columns past the right edge are clipped, never wrapped.
// -----------------------------------------------------------------------------
module sprite_row_xor (
  input  logic [63:0] i_old_row,
  input  logic [7:0]  i_byte,
  input  logic [5:0]  i_x0,
  output logic [63:0] o_new_row,
  output logic        o_collide
);

  logic [63:0] w_mask;
  logic [6:0]  w_col;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_mask = '0;
    w_col  = '0;
    for (int b = 0; b < 8; b++) begin
      // Seven-bit sum so a column past 63 shows up in bit 6 and is dropped.
      w_col = {1'b0, i_x0} + 7'(7 - b);
      if (i_byte[b] && !w_col[6]) begin
        w_mask[w_col[5:0]] = 1'b1;
      end
    end
  end

  assign o_new_row = i_old_row ^ w_mask;
  assign o_collide = |(i_old_row & w_mask);

endmodule

// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter -- CHIP-8 framebuffer with clear and XOR sprite draw.
//   clk, rst            : clock, synchronous active-high reset
//   gpu_clear, gpu_draw : command strobes, sampled only while idle
//   vx, vy, n_bits      : sprite origin (taken mod screen size) and height
//   sprite_data         : 15 sprite rows, row r in [119-8r -: 8]
//   busy, done          : command in progress / one-cycle completion pulse
//   vf                  : collision result of the last command (8'h01/8'h00)
//   rd_row, rd_data     : registered display read port
// A draw spends one cycle per sprite row (clipped rows included), a clear one
// cycle per screen row, then one FINISH cycle that pulses done.
// -----------------------------------------------------------------------------
module sprite_blitter #(
  parameter int SCREEN_W = chip8_defs::SCREEN_W,
  parameter int SCREEN_H = chip8_defs::SCREEN_H
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                gpu_clear,
  input  logic                gpu_draw,
  input  logic [7:0]          vx,
  input  logic [7:0]          vy,
  input  logic [3:0]          n_bits,
  input  logic [119:0]        sprite_data,
  output logic                busy,
  output logic                done,
  output logic [7:0]          vf,
  input  logic [4:0]          rd_row,
  output logic [SCREEN_W-1:0] rd_data
);

  import chip8_defs::*;

  gpu_state_e          r_state;
  gpu_state_e          w_next;
  logic [4:0]          r_row;
  logic [3:0]          r_n;
  logic [5:0]          r_x0;
  logic [4:0]          r_y0;
  logic [119:0]        r_sprite;
  logic                r_coll;
  logic [7:0]          r_vf;
  logic [SCREEN_W-1:0] r_rd_data;
  logic [SCREEN_W-1:0] r_fb [SCREEN_H];

  logic [5:0]          w_row_y;
  logic                w_row_on;
  logic [SCREEN_W-1:0] w_new_row;
  logic                w_collide;
  logic                w_last_draw;
  logic                w_last_clear;
  logic                w_unused;

  // Origin bits above the screen size are discarded (coordinates wrap).
  assign w_unused = &{1'b0, vx[7:6], vy[7:5]};

  // Target row of the current sprite row; bit 5 set means below the screen.
  assign w_row_y      = {1'b0, r_y0} + {1'b0, r_row};
  assign w_row_on     = ~w_row_y[5];
  assign w_last_draw  = (r_row[3:0] == r_n - 4'd1);
  assign w_last_clear = (r_row == 5'(SCREEN_H - 1));

  sprite_row_xor u_row_xor (
    .i_old_row (r_fb[w_row_y[4:0]]),
    .i_byte    (r_sprite[119 -: 8]),
    .i_x0      (r_x0),
    .o_new_row (w_new_row),
    .o_collide (w_collide)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (gpu_clear)     w_next = CLEAR;
        else if (gpu_draw) w_next = (n_bits == 4'd0) ? FINISH : DRAW;
      end
      CLEAR:  if (w_last_clear) w_next = FINISH;
      DRAW:   if (w_last_draw)  w_next = FINISH;
      FINISH: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: the framebuffer is reset row by row here because a reset must leave
  // the screen blank; that rules out a plain RAM macro for this array.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row     <= '0;
      r_n       <= '0;
      r_x0      <= '0;
      r_y0      <= '0;
      r_sprite  <= '0;
      r_coll    <= 1'b0;
      r_vf      <= '0;
      r_rd_data <= '0;
      for (int i = 0; i < SCREEN_H; i++) r_fb[i] <= '0;
    end else begin
      // NOTE: non-blocking assignment means this read sees the row value from
      // before any write on the same edge.
      r_rd_data <= r_fb[rd_row];
      case (r_state)
        IDLE: begin
          r_row  <= '0;
          r_coll <= 1'b0;
          if (!gpu_clear && gpu_draw) begin
            r_x0     <= vx[5:0];
            r_y0     <= vy[4:0];
            r_n      <= n_bits;
            r_sprite <= sprite_data;
          end
        end
        CLEAR: begin
          r_fb[r_row] <= '0;
          r_row       <= r_row + 5'd1;
        end
        DRAW: begin
          // Rows below the screen still cost a cycle to keep latency fixed.
          if (w_row_on) begin
            r_fb[w_row_y[4:0]] <= w_new_row;
            r_coll             <= r_coll | w_collide;
          end
          r_sprite <= r_sprite << 8;
          r_row    <= r_row + 5'd1;
        end
        FINISH:  r_vf <= {7'd0, r_coll};
        default: ;
      endcase
    end
  end

  assign vf      = r_vf;
  assign rd_data = r_rd_data;

endmodule
